key_switch_conditioner: RTL and testbench

- Parametrised input-conditioning front end between the board's raw push-buttons/slide switches and the CPU's memory-mapped I/O.
- Per channel: two-flop synchronisation, counter debounce, press-edge pulses and optional auto-repeat.
- Each key has a sticky pending flag and an overrun flag; the CPU clears them with write-1-to-clear.
- Replaces the ad-hoc direct KEY/SW sampling inside the computer top level.

---
 rtl/io_cond_pkg.sv | 9 +
 rtl/debounce_cell.sv | 37 +++
 rtl/key_switch_conditioner.sv | 84 ++++++++
 tb/tb_key_switch_conditioner.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/io_cond_pkg.sv
// io_cond_pkg: shared types and helpers for the key/switch input conditioner.
package io_cond_pkg;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;
  localparam logic KEY_RELEASED_ACTIVE_LOW = 1'b1;
  localparam logic KEY_RELEASED_ACTIVE_HIGH = 1'b0;
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: two-flop synchroniser plus counter debounce; accept is high in the cycle before level flips.
module debounce_cell
  import io_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic raw,
  output logic level,
  output logic accept
);
  localparam int W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);
  logic meta_q, sync_q, level_q, level_d;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    accept = (sync_q != level_q) && (cnt_q == LAST);
    level_d = accept ? sync_q : level_q;
    cnt_d = ((sync_q == level_q) || accept) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      meta_q <= RESET_LEVEL;
      sync_q <= RESET_LEVEL;
      level_q <= RESET_LEVEL;
      cnt_q <= '0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
      level_q <= level_d;
      cnt_q <= cnt_d;
    end
  end
  assign level = level_q;
endmodule

// File: rtl/key_switch_conditioner.sv
// key_switch_conditioner: debounced keys and switches with press pulses, auto-repeat
// and write-1-to-clear pending/overrun flags for memory-mapped I/O.
module key_switch_conditioner
  import io_cond_pkg::*;
#(
  parameter int NUM_KEYS = 4,
  parameter int NUM_SW = 10,
  parameter bit KEY_ACTIVE_LOW = 1'b1,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic [NUM_KEYS-1:0] KEY,
  input  logic [NUM_SW-1:0]   SW,
  input  logic [NUM_KEYS-1:0] repeat_en,
  input  logic [NUM_KEYS-1:0] clr_pending,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] pending,
  output logic [NUM_KEYS-1:0] overrun,
  output logic [NUM_SW-1:0]   sw_level,
  output logic                sw_change
);
  localparam logic KEY_REL = KEY_ACTIVE_LOW ? KEY_RELEASED_ACTIVE_LOW : KEY_RELEASED_ACTIVE_HIGH;
  localparam int RW = cnt_width(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [RW-1:0] LAST_DELAY = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] LAST_PERIOD = RW'(REPEAT_PERIOD - 1);
  logic [NUM_SW-1:0] sw_acc;
  logic sw_change_q, sw_change_d;
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic raw_lvl, acc, lvl, press_acc, rel_acc, stop, hit;
    logic press_q, press_d, pend_q, pend_d, ovr_q, ovr_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    rpt_state_t state_q, state_d;
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(KEY_REL)) u_cell (
      .Clock(Clock), .Resetn(Resetn), .raw(KEY[k]), .level(raw_lvl), .accept(acc)
    );
    // accept always toggles the level, so its direction follows from the current level
    always_comb begin
      lvl = raw_lvl ^ KEY_REL;
      press_acc = acc & ~lvl;
      rel_acc = acc & lvl;
      stop = ~repeat_en[k] | rel_acc;
      hit = (state_q == DELAY && rcnt_q == LAST_DELAY) || (state_q == REPEAT && rcnt_q == LAST_PERIOD);
      state_d = stop ? IDLE : press_acc ? DELAY : hit ? REPEAT : state_q;
      rcnt_d = (stop || press_acc || hit || state_q == IDLE) ? '0 : rcnt_q + 1'b1;
      press_d = press_acc | (hit & ~stop);
      pend_d = press_q | (pend_q & ~clr_pending[k]);
      ovr_d = ~clr_pending[k] & (ovr_q | (press_q & pend_q));
    end
    always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
        state_q <= IDLE;
        rcnt_q <= '0;
        press_q <= 1'b0;
        pend_q <= 1'b0;
        ovr_q <= 1'b0;
      end else begin
        state_q <= state_d;
        rcnt_q <= rcnt_d;
        press_q <= press_d;
        pend_q <= pend_d;
        ovr_q <= ovr_d;
      end
    end
    assign key_level[k] = lvl;
    assign key_press[k] = press_q;
    assign pending[k] = pend_q;
    assign overrun[k] = ovr_q;
  end
  for (genvar s = 0; s < NUM_SW; s++) begin : g_sw
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b0)) u_cell (
      .Clock(Clock), .Resetn(Resetn), .raw(SW[s]), .level(sw_level[s]), .accept(sw_acc[s])
    );
  end
  always_comb sw_change_d = |sw_acc;
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) sw_change_q <= 1'b0;
    else sw_change_q <= sw_change_d;
  end
  assign sw_change = sw_change_q;
endmodule

// File: tb/tb_key_switch_conditioner.sv
// tb_key_switch_conditioner: directed stimulus with a pulse scoreboard checked by an independent monitor.
module tb_key_switch_conditioner;
  logic Clock = 1'b0;
  logic Resetn = 1'b1;
  logic [3:0] KEY = 4'hF;
  logic [9:0] SW = '0;
  logic [3:0] repeat_en = '0;
  logic [3:0] clr_pending = '0;
  logic [3:0] key_level, key_press, pending, overrun;
  logic [9:0] sw_level;
  logic sw_change;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int cyc;
    logic [3:0] kp;
    logic swc;
    logic [9:0] swl;
    logic [3:0] kl;
  } exp_t;
  exp_t sb[$];

  key_switch_conditioner #(
    .NUM_KEYS(4), .NUM_SW(10), .KEY_ACTIVE_LOW(1'b1),
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .KEY(KEY), .SW(SW), .repeat_en(repeat_en),
    .clr_pending(clr_pending), .key_level(key_level), .key_press(key_press),
    .pending(pending), .overrun(overrun), .sw_level(sw_level), .sw_change(sw_change)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic push(input int c, input logic [3:0] kp, input logic swc, input logic [9:0] swl, input logic [3:0] kl);
    exp_t e;
    e.cyc = c; e.kp = kp; e.swc = swc; e.swl = swl; e.kl = kl;
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (|key_press || sw_change) begin
        if (sb.size() == 0) check("unexpected_pulse", {key_press, sw_change, sw_level}, 64'h0);
        else begin
          e = sb.pop_front();
          check("pulse{cyc,kp,swc,swl,kl}", {cyc, key_press, sw_change, sw_level, key_level},
                {e.cyc, e.kp, e.swc, e.swl, e.kl});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    #2 Resetn = 1'b0;
    tick(3);
    Resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("idle_outputs", {key_level, key_press, pending, overrun, sw_level, sw_change}, 64'h0);
    end
    // basic press on KEY[3]
    KEY[3] = 1'b0;
    push(cyc + 6, 4'h8, 1'b0, 10'h0, 4'h8);
    tick(5);
    check("level3_before_latency", key_level, 4'h0);
    tick(2);
    check("pending3_set", pending, 4'h8);
    check("level3_held", key_level, 4'h8);
    KEY[3] = 1'b1;
    tick(8);
    check("level3_released", key_level, 4'h0);
    clr_pending = 4'h8;
    tick(1);
    clr_pending = 4'h0;
    check("pending_cleared", {pending, overrun}, 8'h0);
    // 3-cycle glitch is rejected, 5-cycle press is accepted
    KEY[3] = 1'b0;
    tick(3);
    KEY[3] = 1'b1;
    tick(10);
    check("glitch_level", key_level, 4'h0);
    check("glitch_pending", pending, 4'h0);
    KEY[3] = 1'b0;
    push(cyc + 6, 4'h8, 1'b0, 10'h0, 4'h8);
    tick(5);
    KEY[3] = 1'b1;
    tick(1);
    check("short_press_level", key_level, 4'h8);
    tick(10);
    check("short_press_released", key_level, 4'h0);
    clr_pending = 4'h8;
    tick(1);
    clr_pending = 4'h0;
    // auto-repeat over a 40-cycle hold
    repeat_en = 4'h8;
    KEY[3] = 1'b0;
    e0 = cyc;
    push(e0 + 6, 4'h8, 1'b0, 10'h0, 4'h8);
    for (int t = e0 + 14; t < e0 + 46; t += 4) push(t, 4'h8, 1'b0, 10'h0, 4'h8);
    tick(40);
    KEY[3] = 1'b1;
    tick(10);
    check("repeat_pending_overrun", {pending, overrun}, {4'h8, 4'h8});
    check("repeat_released", key_level, 4'h0);
    clr_pending = 4'h8;
    tick(1);
    clr_pending = 4'h0;
    // dropping repeat_en mid-hold stops repeats; re-enabling does not restart them
    KEY[3] = 1'b0;
    e0 = cyc;
    push(e0 + 6, 4'h8, 1'b0, 10'h0, 4'h8);
    push(e0 + 14, 4'h8, 1'b0, 10'h0, 4'h8);
    tick(16);
    repeat_en = 4'h0;
    tick(4);
    repeat_en = 4'h8;
    tick(20);
    KEY[3] = 1'b1;
    tick(10);
    repeat_en = 4'h0;
    check("stop_repeat_flags", {pending, overrun}, {4'h8, 4'h8});
    clr_pending = 4'h8;
    tick(1);
    clr_pending = 4'h0;
    // clear colliding with a press on KEY[0] while pending is already set
    KEY[0] = 1'b0;
    push(cyc + 6, 4'h1, 1'b0, 10'h0, 4'h1);
    tick(8);
    KEY[0] = 1'b1;
    tick(8);
    check("pending0_preset", {pending, overrun}, {4'h1, 4'h0});
    KEY[0] = 1'b0;
    push(cyc + 6, 4'h1, 1'b0, 10'h0, 4'h1);
    tick(6);
    clr_pending = 4'h1;
    tick(1);
    clr_pending = 4'h0;
    check("clr_vs_press", {pending, overrun}, {4'h1, 4'h0});
    clr_pending = 4'h1;
    tick(1);
    clr_pending = 4'h0;
    check("clr_only", {pending, overrun}, 8'h0);
    KEY[0] = 1'b1;
    tick(8);
    // two switches change together: one sw_change pulse
    SW = 10'h003;
    push(cyc + 6, 4'h0, 1'b1, 10'h003, 4'h0);
    tick(5);
    check("sw_before_latency", sw_level, 10'h000);
    tick(1);
    check("sw_level_003", sw_level, 10'h003);
    tick(4);
    // reset during a switch debounce, then switches already on at reset release
    SW = 10'h3FC;
    tick(3);
    Resetn = 1'b0;
    #1;
    check("async_reset_outputs", {key_level, key_press, pending, overrun, sw_level, sw_change}, 64'h0);
    tick(2);
    Resetn = 1'b1;
    push(cyc + 6, 4'h0, 1'b1, 10'h3FC, 4'h0);
    tick(12);
    check("sw_level_after_reset", sw_level, 10'h3FC);
    tick(5);
    check("scoreboard_empty", 64'(sb.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
